// File: rtl/cic_comb_sequencer_if.sv
// Sample path between decimator, comb chain and CIC output port.
// Latency: none (wires only).
// Backpressure: none; the sequencer drops strobes that arrive while it is busy.
interface cic_comb_sequencer_if #(
    parameter int SAMP_WIDTH = 8
);
    logic [SAMP_WIDTH-1:0] samp_inp_data;
    logic                  samp_inp_str;
    logic [SAMP_WIDTH-1:0] chain_inp_data;
    logic [SAMP_WIDTH-1:0] chain_out_data;
    logic                  summ_rdy_str;
    logic [SAMP_WIDTH-1:0] samp_out_data;
    logic                  samp_out_str;

    // master = decimator/comb-chain side, slave = sequencer
    modport master (
        output samp_inp_data,
        output samp_inp_str,
        output chain_out_data,
        input  chain_inp_data,
        input  summ_rdy_str,
        input  samp_out_data,
        input  samp_out_str
    );

    modport slave (
        input  samp_inp_data,
        input  samp_inp_str,
        input  chain_out_data,
        output chain_inp_data,
        output summ_rdy_str,
        output samp_out_data,
        output samp_out_str
    );
endinterface

// File: rtl/cic_comb_sequencer.sv
// Sequences one sample through an unregistered comb chain: hold, settle, latch, push.
// Latency: strobe cycle 0 -> samp_out_str/summ_rdy_str in cycle CIC_N.
// Backpressure: none; strobes while busy are dropped and counted (sticky overrun).
module cic_comb_sequencer #(
    parameter int SAMP_WIDTH = 8,
    parameter int CIC_N      = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  clear_i,
    cic_comb_sequencer_if.slave   bus,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic [DROP_WIDTH-1:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LATCH  = 2'd2,
        PUSH   = 2'd3
    } state_t;

    localparam int             CNT_W       = $clog2(CIC_N + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CIC_N - 2);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [SAMP_WIDTH-1:0] chain_inp_q;
    logic [SAMP_WIDTH-1:0] samp_out_q;
    logic                  push_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic                  overrun_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q;
    logic [DROP_WIDTH-1:0] drop_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            chain_inp_q <= '0;
            samp_out_q  <= '0;
            push_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.samp_inp_str && enable_i) begin
                        chain_inp_q <= bus.samp_inp_data;
                        cnt_q       <= CNT_W'(1);
                        busy_q      <= 1'b1;
                        state_q     <= (CIC_N > 2) ? SETTLE : LATCH;
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    // Ripple has had CIC_N-1 clocks; capture at this closing edge.
                    samp_out_q <= bus.chain_out_data;
                    push_q     <= 1'b1;
                    state_q    <= PUSH;
                end
                PUSH: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Overrun ignores enable; clear beats a coincident dropped strobe.
    always_comb begin
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            overrun_d  = 1'b0;
            drop_cnt_d = '0;
        end else if (bus.samp_inp_str && (state_q != IDLE)) begin
            overrun_d = 1'b1;
            if (drop_cnt_q != {DROP_WIDTH{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.chain_inp_data = chain_inp_q;
    assign bus.samp_out_data  = samp_out_q;
    assign bus.summ_rdy_str   = push_q;
    assign bus.samp_out_str   = push_q;
    assign busy_o             = busy_q;
    assign overrun_o          = overrun_q;
    assign drop_cnt_o         = drop_cnt_q;

endmodule

// File: tb/tb_cic_comb_sequencer.sv
// Directed bench: three sequencer instances (CIC_N=4, CIC_N=2, DROP_WIDTH=2).
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
module tb_cic_comb_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance A: CIC_N=4, DROP_WIDTH=8
    logic       en_a, clr_a, busy_a, ovr_a;
    logic [7:0] drop_a;
    cic_comb_sequencer_if #(.SAMP_WIDTH(8)) if_a ();
    cic_comb_sequencer #(.SAMP_WIDTH(8), .CIC_N(4), .DROP_WIDTH(8)) u_a (
        .clk(clk), .reset_n(reset_n), .enable_i(en_a), .clear_i(clr_a),
        .bus(if_a.slave), .busy_o(busy_a), .overrun_o(ovr_a), .drop_cnt_o(drop_a)
    );

    // instance B: CIC_N=2
    logic       en_b, clr_b, busy_b, ovr_b;
    logic [7:0] drop_b;
    cic_comb_sequencer_if #(.SAMP_WIDTH(8)) if_b ();
    cic_comb_sequencer #(.SAMP_WIDTH(8), .CIC_N(2), .DROP_WIDTH(8)) u_b (
        .clk(clk), .reset_n(reset_n), .enable_i(en_b), .clear_i(clr_b),
        .bus(if_b.slave), .busy_o(busy_b), .overrun_o(ovr_b), .drop_cnt_o(drop_b)
    );

    // instance C: CIC_N=4, DROP_WIDTH=2
    logic       en_c, clr_c, busy_c, ovr_c;
    logic [1:0] drop_c;
    cic_comb_sequencer_if #(.SAMP_WIDTH(8)) if_c ();
    cic_comb_sequencer #(.SAMP_WIDTH(8), .CIC_N(4), .DROP_WIDTH(2)) u_c (
        .clk(clk), .reset_n(reset_n), .enable_i(en_c), .clear_i(clr_c),
        .bus(if_c.slave), .busy_o(busy_c), .overrun_o(ovr_c), .drop_cnt_o(drop_c)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic saw_push;
    logic [7:0] vec_b [3];

    initial begin
        en_a = 1'b1; clr_a = 1'b0; en_b = 1'b1; clr_b = 1'b0; en_c = 1'b1; clr_c = 1'b0;
        if_a.samp_inp_data = '0; if_a.samp_inp_str = 1'b0; if_a.chain_out_data = '0;
        if_b.samp_inp_data = '0; if_b.samp_inp_str = 1'b0; if_b.chain_out_data = '0;
        if_c.samp_inp_data = '0; if_c.samp_inp_str = 1'b0; if_c.chain_out_data = '0;
        vec_b[0] = 8'h81; vec_b[1] = 8'h7e; vec_b[2] = 8'h00;

        tick(); tick();
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_chain_inp", {24'd0, if_a.chain_inp_data}, 32'd0);
        check("rst_samp_out", {24'd0, if_a.samp_out_data}, 32'd0);
        check("rst_push", {30'd0, if_a.summ_rdy_str, if_a.samp_out_str}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: reset mid-SETTLE aborts, clears overrun/drop, no push afterwards
        if_a.samp_inp_data = 8'h9c; if_a.samp_inp_str = 1'b1;
        tick();                                  // cycle 1, dropped strobe still high
        tick();                                  // cycle 2
        if_a.samp_inp_str = 1'b0;
        check("t1_ovr_before_rst", {24'd0, drop_a}, 32'd1);
        check("t1_busy_before_rst", {31'd0, busy_a}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t1_rst_busy", {31'd0, busy_a}, 32'd0);
        check("t1_rst_ovr", {31'd0, ovr_a}, 32'd0);
        check("t1_rst_drop", {24'd0, drop_a}, 32'd0);
        check("t1_rst_chain_inp", {24'd0, if_a.chain_inp_data}, 32'd0);
        tick();
        reset_n = 1'b1;
        saw_push = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_push = saw_push | if_a.summ_rdy_str | busy_a;
        end
        check("t1_no_push_after_rst", {31'd0, saw_push}, 32'd0);

        // 2: basic sequence, CIC_N=4
        if_a.samp_inp_data = 8'h12; if_a.samp_inp_str = 1'b1; if_a.chain_out_data = 8'h55;
        check("t2_busy_c0", {31'd0, busy_a}, 32'd0);
        tick();                                  // cycle 1
        if_a.samp_inp_str = 1'b0; if_a.samp_inp_data = 8'hee;
        check("t2_busy_c1", {31'd0, busy_a}, 32'd1);
        check("t2_chain_inp", {24'd0, if_a.chain_inp_data}, 32'h12);
        check("t2_no_push_c1", {31'd0, if_a.summ_rdy_str}, 32'd0);
        tick();                                  // cycle 2
        check("t2_no_push_c2", {31'd0, if_a.samp_out_str}, 32'd0);
        tick();                                  // cycle 3
        if_a.chain_out_data = 8'h34;
        check("t2_no_push_c3", {31'd0, if_a.samp_out_str}, 32'd0);
        check("t2_samp_out_c3", {24'd0, if_a.samp_out_data}, 32'd0);
        tick();                                  // cycle 4
        if_a.chain_out_data = 8'h77;
        check("t2_str_c4", {30'd0, if_a.summ_rdy_str, if_a.samp_out_str}, 32'd3);
        check("t2_samp_out_c4", {24'd0, if_a.samp_out_data}, 32'h34);
        check("t2_busy_c4", {31'd0, busy_a}, 32'd1);
        check("t2_chain_inp_c4", {24'd0, if_a.chain_inp_data}, 32'h12);
        tick();                                  // cycle 5
        check("t2_str_c5", {30'd0, if_a.summ_rdy_str, if_a.samp_out_str}, 32'd0);
        check("t2_busy_c5", {31'd0, busy_a}, 32'd0);
        check("t2_samp_out_hold", {24'd0, if_a.samp_out_data}, 32'h34);

        // 4: overrun at cycle 2 and in PUSH
        if_a.samp_inp_data = 8'ha5; if_a.samp_inp_str = 1'b1;
        tick();                                  // cycle 1
        if_a.samp_inp_str = 1'b0;
        tick();                                  // cycle 2
        if_a.samp_inp_data = 8'h5a; if_a.samp_inp_str = 1'b1;
        tick();                                  // cycle 3
        if_a.samp_inp_str = 1'b0; if_a.chain_out_data = 8'hc3;
        check("t4_ovr", {31'd0, ovr_a}, 32'd1);
        check("t4_drop1", {24'd0, drop_a}, 32'd1);
        check("t4_chain_inp", {24'd0, if_a.chain_inp_data}, 32'ha5);
        tick();                                  // cycle 4 (PUSH)
        if_a.samp_inp_data = 8'h11; if_a.samp_inp_str = 1'b1;
        check("t4_out_str", {31'd0, if_a.samp_out_str}, 32'd1);
        check("t4_samp_out", {24'd0, if_a.samp_out_data}, 32'hc3);
        tick();                                  // cycle 5
        if_a.samp_inp_str = 1'b0;
        check("t4_drop2", {24'd0, drop_a}, 32'd2);
        check("t4_busy_c5", {31'd0, busy_a}, 32'd0);
        check("t4_chain_inp_c5", {24'd0, if_a.chain_inp_data}, 32'ha5);

        // 6: clear, enable low in IDLE, enable dropping mid-sequence
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("t6_clr_ovr", {31'd0, ovr_a}, 32'd0);
        check("t6_clr_drop", {24'd0, drop_a}, 32'd0);
        en_a = 1'b0; if_a.samp_inp_data = 8'hf0; if_a.samp_inp_str = 1'b1;
        tick();
        if_a.samp_inp_str = 1'b0;
        check("t6_dis_busy", {31'd0, busy_a}, 32'd0);
        check("t6_dis_ovr", {31'd0, ovr_a}, 32'd0);
        check("t6_dis_chain_inp", {24'd0, if_a.chain_inp_data}, 32'ha5);
        en_a = 1'b1; if_a.samp_inp_data = 8'h3c; if_a.samp_inp_str = 1'b1;
        tick();                                  // cycle 1
        if_a.samp_inp_str = 1'b0; en_a = 1'b0;
        tick(); tick();                          // cycle 3
        if_a.chain_out_data = 8'h66;
        tick();                                  // cycle 4
        check("t6_mid_dis_str", {31'd0, if_a.samp_out_str}, 32'd1);
        check("t6_mid_dis_out", {24'd0, if_a.samp_out_data}, 32'h66);
        check("t6_mid_dis_inp", {24'd0, if_a.chain_inp_data}, 32'h3c);
        en_a = 1'b1;
        tick();

        // 3: CIC_N=2, back-to-back strobes every 3 clocks
        for (int i = 0; i < 3; i++) begin
            if_b.samp_inp_data = vec_b[i]; if_b.samp_inp_str = 1'b1;
            tick();                              // cycle 1 (LATCH)
            if_b.samp_inp_str = 1'b0; if_b.chain_out_data = ~vec_b[i];
            check($sformatf("t3_busy_c1_%0d", i), {31'd0, busy_b}, 32'd1);
            check($sformatf("t3_nopush_c1_%0d", i), {31'd0, if_b.summ_rdy_str}, 32'd0);
            tick();                              // cycle 2 (PUSH)
            check($sformatf("t3_push_c2_%0d", i), {30'd0, if_b.summ_rdy_str, if_b.samp_out_str}, 32'd3);
            check($sformatf("t3_out_%0d", i), {24'd0, if_b.samp_out_data}, {24'd0, ~vec_b[i]});
            check($sformatf("t3_inp_%0d", i), {24'd0, if_b.chain_inp_data}, {24'd0, vec_b[i]});
            tick();                              // next cycle 0
        end
        check("t3_no_ovr", {31'd0, ovr_b}, 32'd0);
        check("t3_no_drop", {24'd0, drop_b}, 32'd0);

        // 5: DROP_WIDTH=2 saturation, clear beats coincident overrun
        if_c.samp_inp_data = 8'h42; if_c.samp_inp_str = 1'b1;
        tick(); tick(); tick(); tick();          // cycle 4: drops in cycles 1..3
        check("t5_drop3", {30'd0, drop_c}, 32'd3);
        tick(); tick(); tick();                  // cycle 7: drops in 1..4 and 6
        check("t5_sat", {30'd0, drop_c}, 32'd3);
        check("t5_ovr", {31'd0, ovr_c}, 32'd1);
        clr_c = 1'b1;                            // strobe still high: coincident overrun
        tick();                                  // cycle 8
        clr_c = 1'b0; if_c.samp_inp_str = 1'b0;
        check("t5_clr_drop", {30'd0, drop_c}, 32'd0);
        check("t5_clr_ovr", {31'd0, ovr_c}, 32'd0);
        tick();                                  // cycle 9
        check("t5_second_push", {31'd0, if_c.samp_out_str}, 32'd1);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
